fp_to_int33: RTL and testbench
==============================

FP_TO_INT33 -- requirements
Module: fp_to_int33

Interface
REQ-001 SHALL have parameter LATENCY, default 7, pipeline depth in cycles from input capture to result; fixed at 7.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port areset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk).
REQ-004 SHALL have port in_valid  input  1  a is a conversion request this cycle.
REQ-005 SHALL have port a  input  32  IEEE-754 binary32 operand.
REQ-006 SHALL have port out_valid  output  1  q/flags hold a completed result this cycle.
REQ-007 SHALL have port q  output  33  two's-complement signed integer result.
REQ-008 SHALL have port invalid  output  1  NaN, infinity or out-of-range operand; q saturated.
REQ-009 SHALL have port inexact  output  1  nonzero fraction discarded by truncation.

Function
REQ-010 SHALL convert a to a 33-bit signed integer, rounding toward zero, covering the full signed and unsigned 32-bit result range.
REQ-011 SHALL present the result of a request sampled at edge N on q/invalid/inexact with out_valid=1 exactly after edge N+7.
REQ-012 SHALL accept one request per cycle with no stalls; no backpressure input exists; back-to-back requests emerge back-to-back in order.
REQ-013 SHALL drive out_valid=0 in cycles carrying no request; q/flags in those cycles SHALL be 0.
REQ-014 SHALL treat exponent field 0 (zero, subnormal) as value 0: q=0; inexact=1 iff fraction nonzero; invalid=0.
REQ-015 SHALL yield q=0 for both +0 and -0, flags 0.
REQ-016 SHALL, for unbiased exponent e in 0..31, form the 24-bit significand (hidden 1), shift left by e-23 when e>=23 else right by 23-e, set inexact from OR of shifted-out bits, and negate if sign=1.
REQ-017 SHALL, for e<0 with nonzero value, give q=0, inexact=1, invalid=0.
REQ-018 SHALL, for e=32 with sign=1 and fraction 0 (exactly -2^32), give q=0x1_0000_0000, flags 0.
REQ-019 SHALL saturate all other e>=32 and infinities: positive -> 0x0_FFFF_FFFF, negative -> 0x1_0000_0000, invalid=1, inexact=0.
REQ-020 SHALL give any NaN (quiet or signalling, either sign) q=0x0_FFFF_FFFF, invalid=1, inexact=0.
REQ-021 SHALL never assert invalid and inexact together.
REQ-022 SHALL split work across stages: 1 unpack/classify, 2 shift-amount compute, 3-5 shift (≤3 shift bits per stage, sticky accumulated), 6 conditional negate, 7 saturate/register outputs.

Reset
REQ-023 SHALL, while areset=0 at an edge, clear every valid bit in the pipeline and set out_valid=0, q=0, invalid=0, inexact=0 after that edge.
REQ-024 SHALL discard all in-flight requests on reset; none emerge after release.
REQ-025 SHALL accept a request in the first cycle with areset=1; its result appears 7 cycles later.
REQ-026 SHALL ignore in_valid in cycles where areset=0.

Structure
REQ-027 SHALL take from the shared floating-point package: binary32 bias (127), field widths, INT33_MAX (0x0_FFFF_FFFF), INT33_MIN (0x1_0000_0000), latency constant 7.
REQ-028 SHALL implement the multi-stage shifter as one sub-module, fp_to_int33_shift (significand, shift amount, direction -> shifted value, sticky), holding stages 3-5.
REQ-029 SHALL contain no DPI or simulation-only constructs; fully synthesizable.

Verification
REQ-030 SHALL check a=0x3F80_0000 (1.0), in_valid=1 -> 7 cycles later q=0x0_0000_0001, out_valid=1, flags 0.
REQ-031 SHALL check a=0xBFC0_0000 (-1.5) -> q=0x1_FFFF_FFFF, inexact=1; a=0x4F7F_FFFF -> q=0x0_FFFF_FF00, flags 0.
REQ-032 SHALL check a=0x4F80_0000 (2^32) -> q=0x0_FFFF_FFFF, invalid=1; a=0xCF80_0000 -> q=0x1_0000_0000, invalid=0; a=0x7FC0_0000 -> q=0x0_FFFF_FFFF, invalid=1.
REQ-033 SHALL check a=0x0000_0001 (subnormal) -> q=0, inexact=1; a=0x8000_0000 -> q=0, flags 0.
REQ-034 SHALL check 20 consecutive valid requests with random operands -> 20 consecutive out_valid cycles, in order, each matching a reference model.
REQ-035 SHALL check areset=0 for one cycle with 4 requests in flight -> out_valid=0 and q=0 for the next 7 cycles; request issued on release emerges after 7 cycles.

Source files
------------

// File: rtl/fp_to_int33_pkg.sv
// Shared binary32 constants and types for the
// float-to-int33 converter pipeline.
package fp_to_int33_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int BIAS   = 127;
  localparam int LAT    = 7;

  localparam logic [32:0] INT33_MAX = 33'h0_FFFF_FFFF;
  localparam logic [32:0] INT33_MIN = 33'h1_0000_0000;

  typedef enum logic [2:0] {
    C_ZERO,
    C_NORM,
    C_SATP,
    C_SATN,
    C_MIN
  } cls_t;

  typedef struct packed {
    cls_t cls;
    logic sign;
    logic zinx;
  } side_t;

  function automatic logic lost(
    input logic [31:0] x,
    input logic [4:0]  k
  );
    logic [31:0] m;
    m = (32'd1 << k) - 32'd1;
    return |(x & m);
  endfunction

endpackage

// File: rtl/fp_to_int33_shift.sv
// Three-stage significand shifter; right shifts
// accumulate a sticky bit of discarded ones.
module fp_to_int33_shift
  import fp_to_int33_pkg::*;
(
  input  logic             clk,
  input  logic [SIG_W-1:0] sig,
  input  logic [4:0]       amt,
  input  logic             left,
  output logic [31:0]      val,
  output logic             sticky
);

  logic [31:0] x0;
  logic [31:0] x3;
  logic [31:0] x4;
  logic        st3;
  logic        st4;
  logic [4:2]  a3;
  logic        a4;
  logic        l3;
  logic        l4;

  assign x0 = {8'b0, sig};

  always_ff @(posedge clk) begin
    x3  <= left ? x0 << amt[1:0]
                : x0 >> amt[1:0];
    st3 <= !left && lost(x0, {3'b0, amt[1:0]});
    a3  <= amt[4:2];
    l3  <= left;

    x4  <= l3 ? x3 << {a3[3:2], 2'b0}
              : x3 >> {a3[3:2], 2'b0};
    st4 <= st3 |
           (!l3 && lost(x3, {1'b0, a3[3:2], 2'b0}));
    a4  <= a3[4];
    l4  <= l3;

    val    <= l4 ? x4 << {a4, 4'b0}
                 : x4 >> {a4, 4'b0};
    sticky <= st4 |
              (!l4 && lost(x4, {a4, 4'b0}));
  end

endmodule

// File: rtl/fp_to_int33.sv
// binary32 -> 33-bit signed integer, round toward
// zero, fully pipelined with fixed latency.
module fp_to_int33
  import fp_to_int33_pkg::*;
#(
  parameter int LATENCY = LAT
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        in_valid,
  input  logic [31:0] a,
  output logic        out_valid,
  output logic [32:0] q,
  output logic        invalid,
  output logic        inexact
);

  logic [LATENCY-1:0] vld;
  logic [31:0]        a0;

  cls_t               cls_c;
  logic               zinx_c;
  logic [EXP_W-1:0]   ex;

  side_t              sd1, sd2, sd3, sd4, sd5;
  logic [4:0]         exl1;
  logic [SIG_W-1:0]   sig1, sig2;
  logic [4:0]         e5;
  logic               left_c, left2;
  logic [4:0]         amt_c, amt2;

  logic [31:0]        val5;
  logic               st5;
  logic [32:0]        res6;
  logic               st6;
  cls_t               cls6;
  logic               zinx6;

  logic [32:0]        q_c;
  logic               inv_c;
  logic               inx_c;

  always_ff @(posedge clk) begin
    if (!areset) vld <= '0;
    else vld <= {vld[LATENCY-2:0], in_valid};
  end

  always_ff @(posedge clk) a0 <= a;

  assign ex = a0[30:23];

  always_comb begin
    cls_c  = C_ZERO;
    zinx_c = 1'b0;
    unique case (1'b1)
      ex == 8'd0: zinx_c = |a0[22:0];
      ex != 8'd0 && ex < 8'd127: zinx_c = 1'b1;
      ex >= 8'd127 && ex <= 8'd158: cls_c = C_NORM;
      ex >= 8'd159 && ex != 8'd255: begin
        if (ex == 8'd159 && a0[31] && a0[22:0] == '0)
          cls_c = C_MIN;
        else
          cls_c = a0[31] ? C_SATN : C_SATP;
      end
      ex == 8'd255: begin
        if (a0[22:0] != '0) cls_c = C_SATP;
        else cls_c = a0[31] ? C_SATN : C_SATP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    sd1  <= '{cls: cls_c, sign: a0[31], zinx: zinx_c};
    exl1 <= a0[27:23];
    sig1 <= {1'b1, a0[22:0]};
  end

  // Unbiased exponent is 0..31 for shifted operands, so mod-32 suffices
  assign e5     = exl1 - 5'(BIAS);
  assign left_c = e5 >= 5'd23;
  assign amt_c  = left_c ? e5 - 5'd23 : 5'd23 - e5;

  always_ff @(posedge clk) begin
    sig2  <= sig1;
    amt2  <= amt_c;
    left2 <= left_c;
    sd2   <= sd1;
    sd3   <= sd2;
    sd4   <= sd3;
    sd5   <= sd4;
  end

  fp_to_int33_shift u_shift (
    .clk    (clk),
    .sig    (sig2),
    .amt    (amt2),
    .left   (left2),
    .val    (val5),
    .sticky (st5)
  );

  always_ff @(posedge clk) begin
    res6  <= sd5.sign ? -{1'b0, val5} : {1'b0, val5};
    st6   <= st5;
    cls6  <= sd5.cls;
    zinx6 <= sd5.zinx;
  end

  always_comb begin
    q_c   = '0;
    inv_c = 1'b0;
    inx_c = 1'b0;
    unique case (cls6)
      C_NORM: begin
        q_c   = res6;
        inx_c = st6;
      end
      C_ZERO: inx_c = zinx6;
      C_SATP: begin
        q_c   = INT33_MAX;
        inv_c = 1'b1;
      end
      C_SATN: begin
        q_c   = INT33_MIN;
        inv_c = 1'b1;
      end
      C_MIN: q_c = INT33_MIN;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset || !vld[LATENCY-1]) begin
      out_valid <= 1'b0;
      q         <= '0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      out_valid <= 1'b1;
      q         <= q_c;
      invalid   <= inv_c;
      inexact   <= inx_c;
    end
  end

endmodule

// File: tb/tb_fp_to_int33.sv
// Directed and scoreboarded checks of the
// float-to-int33 converter.
module tb_fp_to_int33;

  logic        clk;
  logic        areset;
  logic        in_valid;
  logic [31:0] a;
  logic        out_valid;
  logic [32:0] q;
  logic        invalid;
  logic        inexact;

  int nvec;
  int nerr;

  fp_to_int33 #(.LATENCY(7)) dut (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .q         (q),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] model(input logic [31:0] x);
    logic        s;
    int          ex;
    int          e;
    logic [22:0] fr;
    longint      mag;
    logic [32:0] qq;
    logic        iv;
    logic        ix;
    s  = x[31];
    ex = int'(x[30:23]);
    fr = x[22:0];
    qq = '0;
    iv = 1'b0;
    ix = 1'b0;
    if (ex == 255) begin
      iv = 1'b1;
      qq = (fr != 0 || !s) ? 33'h0_FFFF_FFFF : 33'h1_0000_0000;
    end else if (ex == 0) begin
      ix = (fr != 0);
    end else begin
      e = ex - 127;
      if (e < 0) begin
        ix = 1'b1;
      end else if (e >= 32) begin
        if (e == 32 && s && fr == 0) begin
          qq = 33'h1_0000_0000;
        end else begin
          iv = 1'b1;
          qq = s ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF;
        end
      end else begin
        mag = longint'({1'b1, fr});
        if (e >= 23) begin
          mag = mag << (e - 23);
        end else begin
          ix  = (mag % (64'sd1 << (23 - e))) != 0;
          mag = mag >> (23 - e);
        end
        if (s) mag = -mag;
        qq = mag[32:0];
      end
    end
    return {iv, ix, qq};
  endfunction

  task automatic test_reset;
    areset   = 1'b0;
    in_valid = 1'b1;
    a        = 32'h3F80_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0 || q !== 33'd0 ||
          invalid !== 1'b0 || inexact !== 1'b0) begin
        nerr++;
        $display("FAIL reset_hold cyc %0d: ov=%b q=%h inv=%b inx=%b want all 0",
                 i, out_valid, q, invalid, inexact);
      end
    end
    areset   = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0 || q !== 33'd0) begin
        nerr++;
        $display("FAIL reset_ignore cyc %0d: ov=%b q=%h want 0/0",
                 i, out_valid, q);
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] va [20];
    logic [32:0] vq [20];
    logic        vi [20];
    logic        vx [20];
    va = '{32'h3F80_0000, 32'hBFC0_0000, 32'h4F7F_FFFF, 32'h4F80_0000,
           32'hCF80_0000, 32'h7FC0_0000, 32'h0000_0001, 32'h8000_0000,
           32'hFF80_0000, 32'h3F00_0000, 32'hFFC0_0000, 32'h4B00_0001,
           32'hCF00_0000, 32'h7F80_0000, 32'hCF80_0001, 32'h0080_0000,
           32'hC049_0FDB, 32'h4EFF_FFFF, 32'h4120_0000, 32'h3F7F_FFFF};
    vq = '{33'h0_0000_0001, 33'h1_FFFF_FFFF, 33'h0_FFFF_FF00, 33'h0_FFFF_FFFF,
           33'h1_0000_0000, 33'h0_FFFF_FFFF, 33'h0_0000_0000, 33'h0_0000_0000,
           33'h1_0000_0000, 33'h0_0000_0000, 33'h0_FFFF_FFFF, 33'h0_0080_0001,
           33'h1_8000_0000, 33'h0_FFFF_FFFF, 33'h1_0000_0000, 33'h0_0000_0000,
           33'h1_FFFF_FFFD, 33'h0_7FFF_FF80, 33'h0_0000_000A, 33'h0_0000_0000};
    vi = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    vx = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = va[i];
      @(negedge clk);
      in_valid = 1'b0;
      a        = 32'h0;
      repeat (6) @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0 || q !== 33'd0) begin
        nerr++;
        $display("FAIL dir_early a=%h: ov=%b q=%h want 0/0",
                 va[i], out_valid, q);
      end
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL dir_valid a=%h: ov=%b want 1", va[i], out_valid);
      end
      nvec++;
      if (q !== vq[i]) begin
        nerr++;
        $display("FAIL dir_q a=%h: q=%h want %h", va[i], q, vq[i]);
      end
      nvec++;
      if (invalid !== vi[i] || inexact !== vx[i]) begin
        nerr++;
        $display("FAIL dir_flags a=%h: inv=%b inx=%b want %b %b",
                 va[i], invalid, inexact, vi[i], vx[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ops [20];
    logic [34:0] exp [20];
    for (int i = 0; i < 20; i++) begin
      ops[i] = {1'($urandom_range(0, 1)),
                8'($urandom_range(100, 165)),
                23'($urandom)};
      exp[i] = model(ops[i]);
    end
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          in_valid = 1'b1;
          a        = ops[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'h0;
      end
      begin
        repeat (9) @(negedge clk);
        for (int j = 0; j < 20; j++) begin
          if (j != 0) @(negedge clk);
          nvec++;
          if (out_valid !== 1'b1 ||
              {invalid, inexact, q} !== exp[j]) begin
            nerr++;
            $display("FAIL b2b[%0d] a=%h: ov=%b inv=%b inx=%b q=%h want 1 %b %b %h",
                     j, ops[j], out_valid, invalid, inexact, q,
                     exp[j][34], exp[j][33], exp[j][32:0]);
          end
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || q !== 33'd0) begin
          nerr++;
          $display("FAIL b2b_tail: ov=%b q=%h want 0/0", out_valid, q);
        end
      end
    join
  endtask

  task automatic test_flush;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 32'h4120_0000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    areset   = 1'b0;
    @(negedge clk);
    areset   = 1'b1;
    in_valid = 1'b1;
    a        = 32'h3F80_0000;
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (out_valid !== 1'b0 || q !== 33'd0) begin
        nerr++;
        $display("FAIL flush cyc %0d: ov=%b q=%h want 0/0",
                 k, out_valid, q);
      end
      @(negedge clk);
      in_valid = 1'b0;
      a        = 32'h0;
    end
    nvec++;
    if (out_valid !== 1'b1 || q !== 33'd1 ||
        invalid !== 1'b0 || inexact !== 1'b0) begin
      nerr++;
      $display("FAIL flush_release: ov=%b q=%h inv=%b inx=%b want 1 1 0 0",
               out_valid, q, invalid, inexact);
    end
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_after: ov=%b want 0", out_valid);
    end
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    areset   = 1'b0;
    in_valid = 1'b0;
    a        = 32'h0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
